// File: rtl/flappy_pkg.sv
// Shared constants, state encoding and helpers for the flappy game sequencer.
package flappy_pkg;

  // Game geometry and physics
  localparam int NUM_COLS    = 6;
  localparam int COL_WIDTH   = 50;
  localparam int GAP_HEIGHT  = 100;
  localparam int COL_SPACING = 160;
  localparam int BIRD_X      = 100;
  localparam int BIRD_W      = 20;
  localparam int BIRD_H      = 30;
  localparam int START_Y     = 240;
  localparam int SCREEN_H    = 480;
  localparam int FLAP_VEL    = 6;
  localparam int MAX_FALL    = 8;
  localparam int DEAD_FRAMES = 60;

  // Column placement: first column left edge, wrap target and new-gap base
  localparam int COL_X0   = 200;
  localparam int WRAP_X   = NUM_COLS * COL_SPACING - 1;
  localparam int GAP_BASE = 64;

  // Coordinate widths: x, y and the common arithmetic width
  localparam int X_W    = 10;
  localparam int Y_W    = 9;
  localparam int A_W    = 11;
  localparam int IDX_W  = 3;
  localparam int DEAD_W = 6;

  // 8-bit Fibonacci LFSR, taps 8,6,5,4 (bits 7,5,4,3)
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_MOVE  = 3'd2,
    ST_CHECK = 3'd3,
    ST_DEAD  = 3'd4
  } state_t;

  // Gap top of column i at game start
  function automatic logic [Y_W-1:0] init_gap_top(input int i);
    logic [Y_W-1:0] g;
    g = 9'd100;
    case (i)
      0: g = 9'd100;
      1: g = 9'd300;
      2: g = 9'd180;
      3: g = 9'd240;
      4: g = 9'd300;
      5: g = 9'd140;
      default: g = 9'd100;
    endcase
    return g;
  endfunction

  // Left edge of column i at game start
  function automatic logic [X_W-1:0] init_col_x(input int i);
    return X_W'(COL_X0 + i * COL_SPACING);
  endfunction

  // One LFSR step: shift left, feedback is the parity of the tapped bits
  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/flappy_col_hit.sv
// Combinational bird-versus-one-column hit test; the controller time-shares
// a single instance across all columns.
module flappy_col_hit
  import flappy_pkg::*;
(
  input  logic [Y_W-1:0] bird_y,
  input  logic [X_W-1:0] col_x,
  input  logic [Y_W-1:0] gap_top,
  output logic           hit
);

  logic [A_W-1:0] cx;
  logic [A_W-1:0] by;
  logic [A_W-1:0] gt;
  logic           overlap_x;
  logic           outside_gap;

  // Widen everything to the unsigned arithmetic width before comparing
  assign cx = A_W'(col_x);
  assign by = A_W'(bird_y);
  assign gt = A_W'(gap_top);

  assign overlap_x   = (A_W'(BIRD_X + BIRD_W) > cx) && (A_W'(BIRD_X) < cx + A_W'(COL_WIDTH));
  assign outside_gap = (by < gt) || (by + A_W'(BIRD_H) > gt + A_W'(GAP_HEIGHT));
  assign hit         = overlap_x && outside_gap;

endmodule

// File: rtl/flappy_game_ctrl.sv
// Frame-rate game sequencer: bird physics, scrolling columns, serial
// collision check and start/dead/restart sequencing.
// Optional feature macro: FLAPPY_SCORE_EN adds the score counter and port.
module flappy_game_ctrl
  import flappy_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    frame_tick,
  input  logic                    flap,
  output logic [Y_W-1:0]          bird_y,
  output logic [NUM_COLS*X_W-1:0] col_x,
  output logic [NUM_COLS*Y_W-1:0] col_gap_top,
  output logic [2:0]              state,
  output logic                    busy,
  output logic                    collided
`ifdef FLAPPY_SCORE_EN
  ,
  output logic [7:0]              score
`endif
);

  localparam logic signed [A_W-1:0] FLAP_S     = A_W'(FLAP_VEL);
  localparam logic signed [A_W-1:0] MAX_FALL_S = A_W'(MAX_FALL);
  localparam logic signed [A_W-1:0] BIRD_H_S   = A_W'(BIRD_H);
  localparam logic signed [A_W-1:0] SCREEN_H_S = A_W'(SCREEN_H);

  state_t                  state_reg, state_next;
  logic [IDX_W-1:0]        idx_reg, idx_next;
  logic [Y_W-1:0]          bird_y_reg, bird_y_next;
  logic signed [A_W-1:0]   vel_reg, vel_next;
  logic [X_W-1:0]          col_x_reg [NUM_COLS];
  logic [X_W-1:0]          col_x_next [NUM_COLS];
  logic [Y_W-1:0]          gap_reg [NUM_COLS];
  logic [Y_W-1:0]          gap_next [NUM_COLS];
  logic [DEAD_W-1:0]       dead_cnt_reg, dead_cnt_next;
  logic [7:0]              lfsr_reg;
  logic                    flap_prev_reg;
  logic                    flap_pending_reg, flap_pending_next;
  logic                    collided_reg, collided_next;
  logic                    busy_reg, busy_next;

  logic                    flap_rise;
  logic signed [A_W-1:0]   vel_n;
  logic signed [A_W-1:0]   y_n;
  logic                    load_init;
  logic                    enter_dead;
  logic [X_W-1:0]          sel_col_x;
  logic [Y_W-1:0]          sel_gap_top;
  logic                    col_hit;

  assign flap_rise   = flap & ~flap_prev_reg;
  assign sel_col_x   = col_x_reg[idx_reg];
  assign sel_gap_top = gap_reg[idx_reg];

  flappy_col_hit u_col_hit (
    .bird_y  (bird_y_reg),
    .col_x   (sel_col_x),
    .gap_top (sel_gap_top),
    .hit     (col_hit)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  // Next-state, physics, column scroll, serial check and dead countdown
  always_comb begin
    state_next        = state_reg;
    idx_next          = idx_reg;
    bird_y_next       = bird_y_reg;
    vel_next          = vel_reg;
    col_x_next        = col_x_reg;
    gap_next          = gap_reg;
    dead_cnt_next     = dead_cnt_reg;
    flap_pending_next = flap_pending_reg | flap_rise;
    vel_n             = '0;
    y_n               = '0;
    load_init         = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (frame_tick && flap_pending_reg) state_next = ST_MOVE;
      end
      ST_WAIT: begin
        if (frame_tick) state_next = ST_MOVE;
      end
      ST_MOVE: begin
        flap_pending_next = 1'b0;
        if (flap_pending_reg)          vel_n = -FLAP_S;
        else if (vel_reg >= MAX_FALL_S) vel_n = MAX_FALL_S;
        else                           vel_n = vel_reg + 11'sd1;
        vel_next = vel_n;
        y_n      = $signed({2'b00, bird_y_reg}) + vel_n;
        // Columns scroll left; one leaving at x=0 re-enters at the far right
        for (int i = 0; i < NUM_COLS; i++) begin
          if (col_x_reg[i] == '0) begin
            col_x_next[i] = X_W'(WRAP_X);
            gap_next[i]   = Y_W'(GAP_BASE) + {1'b0, lfsr_reg};
          end else begin
            col_x_next[i] = col_x_reg[i] - 1'b1;
          end
        end
        if (y_n[A_W-1]) begin
          bird_y_next = '0;
          state_next  = ST_DEAD;
        end else if (y_n + BIRD_H_S > SCREEN_H_S) begin
          bird_y_next = Y_W'(SCREEN_H - BIRD_H);
          state_next  = ST_DEAD;
        end else begin
          bird_y_next = y_n[Y_W-1:0];
          idx_next    = '0;
          state_next  = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (col_hit)                                state_next = ST_DEAD;
        else if (idx_reg == IDX_W'(NUM_COLS - 1))   state_next = ST_WAIT;
        else                                        idx_next   = idx_reg + 1'b1;
      end
      ST_DEAD: begin
        flap_pending_next = 1'b0;
        if (frame_tick) begin
          if (dead_cnt_reg == DEAD_W'(DEAD_FRAMES - 1)) load_init = 1'b1;
          else                                          dead_cnt_next = dead_cnt_reg + 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    if (load_init) begin
      state_next        = ST_IDLE;
      idx_next          = '0;
      bird_y_next       = Y_W'(START_Y);
      vel_next          = '0;
      dead_cnt_next     = '0;
      flap_pending_next = 1'b0;
      for (int i = 0; i < NUM_COLS; i++) begin
        col_x_next[i] = init_col_x(i);
        gap_next[i]   = init_gap_top(i);
      end
    end

    enter_dead = (state_next == ST_DEAD) && (state_reg != ST_DEAD);
    if (enter_dead) dead_cnt_next = '0;
    collided_next = enter_dead;
    busy_next     = (state_next == ST_MOVE) || (state_next == ST_CHECK);
  end

  // Datapath registers; the LFSR free-runs and is seeded only by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_reg          <= '0;
      bird_y_reg       <= Y_W'(START_Y);
      vel_reg          <= '0;
      dead_cnt_reg     <= '0;
      lfsr_reg         <= LFSR_SEED;
      flap_prev_reg    <= 1'b0;
      flap_pending_reg <= 1'b0;
      collided_reg     <= 1'b0;
      busy_reg         <= 1'b0;
      for (int i = 0; i < NUM_COLS; i++) begin
        col_x_reg[i] <= init_col_x(i);
        gap_reg[i]   <= init_gap_top(i);
      end
    end else begin
      idx_reg          <= idx_next;
      bird_y_reg       <= bird_y_next;
      vel_reg          <= vel_next;
      dead_cnt_reg     <= dead_cnt_next;
      lfsr_reg         <= lfsr_step(lfsr_reg);
      flap_prev_reg    <= flap;
      flap_pending_reg <= flap_pending_next;
      collided_reg     <= collided_next;
      busy_reg         <= busy_next;
      col_x_reg        <= col_x_next;
      gap_reg          <= gap_next;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_COLS; gi++) begin : g_pack
      assign col_x[gi*X_W +: X_W]       = col_x_reg[gi];
      assign col_gap_top[gi*Y_W +: Y_W] = gap_reg[gi];
    end
  endgenerate

  assign bird_y   = bird_y_reg;
  assign state    = state_reg;
  assign busy     = busy_reg;
  assign collided = collided_reg;

`ifdef FLAPPY_SCORE_EN
  logic [7:0] score_reg, score_next;
  logic       col_passed;

  assign col_passed = (A_W'(sel_col_x) + A_W'(COL_WIDTH + 1)) == A_W'(BIRD_X);

  // Score: cleared at game start and restart, saturating bump per passed column
  always_comb begin
    score_next = score_reg;
    if (load_init || (state_reg == ST_IDLE && frame_tick && flap_pending_reg))
      score_next = '0;
    else if (state_reg == ST_CHECK && col_passed && score_reg != 8'hFF)
      score_next = score_reg + 8'd1;
  end

  // Score register
  always_ff @(posedge clk) begin
    if (reset) score_reg <= '0;
    else       score_reg <= score_next;
  end

  assign score = score_reg;
`endif

endmodule

// File: tb/tb_flappy_game_ctrl.sv
// Self-checking bench for flappy_game_ctrl against a frame-level game model.
module tb_flappy_game_ctrl;
  import flappy_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_tick;
  logic        flap;
  logic [8:0]  bird_y;
  logic [59:0] col_x;
  logic [53:0] col_gap_top;
  logic [2:0]  state;
  logic        busy;
  logic        collided;
`ifdef FLAPPY_SCORE_EN
  logic [7:0]  score;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  flappy_game_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .frame_tick  (frame_tick),
    .flap        (flap),
    .bird_y      (bird_y),
    .col_x       (col_x),
    .col_gap_top (col_gap_top),
    .state       (state),
    .busy        (busy),
    .collided    (collided)
`ifdef FLAPPY_SCORE_EN
    ,
    .score       (score)
`endif
  );

  // Frame-level model of the game
  int m_y, m_vel, m_score, m_dead_ticks, m_mode;   // mode: 0 idle, 1 playing, 2 dead
  int m_cx[6];
  int m_gap[6];
  bit m_wrap[6];
  bit m_flap;
  int exp_busy, exp_coll;
  int wraps_seen = 0;
  int init_gap[6] = '{100, 300, 180, 240, 300, 140};

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int get_cx(input int i);
    return int'(col_x[i*10 +: 10]);
  endfunction

  function automatic int get_gap(input int i);
    return int'(col_gap_top[i*9 +: 9]);
  endfunction

  task automatic model_init();
    m_y = 240; m_vel = 0; m_score = 0; m_dead_ticks = 0; m_mode = 0; m_flap = 0;
    for (int i = 0; i < 6; i++) begin
      m_cx[i]  = 200 + i * 160;
      m_gap[i] = init_gap[i];
    end
  endtask

  task automatic model_die();
    m_mode = 2; m_dead_ticks = 0; exp_coll = 1; m_flap = 0;
  endtask

  // Predict the effect of one accepted frame tick
  task automatic model_frame();
    int ny;
    exp_busy = 0; exp_coll = 0;
    for (int i = 0; i < 6; i++) m_wrap[i] = 0;
    if (m_mode == 2) begin
      m_dead_ticks++;
      if (m_dead_ticks == 60) model_init();
      return;
    end
    if (m_mode == 0) begin
      if (!m_flap) return;
      m_mode = 1; m_score = 0;
    end
    m_vel = m_flap ? -6 : ((m_vel + 1 > 8) ? 8 : m_vel + 1);
    m_flap = 0;
    ny = m_y + m_vel;
    for (int i = 0; i < 6; i++) begin
      if (m_cx[i] == 0) begin m_cx[i] = 959; m_wrap[i] = 1; end
      else m_cx[i] = m_cx[i] - 1;
    end
    exp_busy = 1;
    if (ny < 0)          begin m_y = 0;   model_die(); return; end
    if (ny + 30 > 480)   begin m_y = 450; model_die(); return; end
    m_y = ny;
    for (int i = 0; i < 6; i++) begin
      exp_busy++;
      if (m_cx[i] + 51 == 100 && m_score < 255) m_score++;
      if (120 > m_cx[i] && 100 < m_cx[i] + 50 &&
          (m_y < m_gap[i] || m_y + 30 > m_gap[i] + 100)) begin
        model_die();
        return;
      end
    end
  endtask

  task automatic press_flap();
    flap = 1'b1;
    repeat ($urandom_range(1, 2)) @(posedge clk);
    #1 flap = 1'b0;
    @(posedge clk); #1;
    m_flap = 1;
  endtask

  task automatic maybe_flap(input int target);
    if (m_y > target || (m_y > target - 4 && $urandom_range(0, 3) == 0)) press_flap();
  endtask

  // Pulse one frame tick, optionally inject a tick while busy, then compare
  task automatic run_frame(input bit allow_drop);
    int cycles, coll, drop_at, exp_state, g;
    model_frame();
    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    frame_tick = 1'b1;
    @(posedge clk); #1;
    frame_tick = 1'b0;
    drop_at = (allow_drop && exp_busy > 0) ? int'($urandom_range(0, exp_busy - 1)) : -1;
    cycles = 0; coll = 0;
    while (busy && cycles < 20) begin
      coll += int'(collided);
      if (cycles == drop_at) frame_tick = 1'b1;
      @(posedge clk); #1;
      frame_tick = 1'b0;
      cycles++;
    end
    coll += int'(collided);
    @(posedge clk); #1;
    coll += int'(collided);
    exp_state = (m_mode == 0) ? int'(ST_IDLE) : (m_mode == 1) ? int'(ST_WAIT) : int'(ST_DEAD);
    chk("busy_cycles", cycles, exp_busy);
    chk("collided_pulses", coll, exp_coll);
    chk("state", int'(state), exp_state);
    chk("bird_y", int'(bird_y), m_y);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("col_x[%0d]", i), get_cx(i), m_cx[i]);
      g = get_gap(i);
      if (m_wrap[i]) begin
        chk($sformatf("wrap_gap_range[%0d]", i), int'(g >= 64 && g <= 319), 1);
        m_gap[i] = g;
        wraps_seen++;
      end else begin
        chk($sformatf("gap_top[%0d]", i), g, m_gap[i]);
      end
    end
`ifdef FLAPPY_SCORE_EN
    chk("score", int'(score), m_score);
`endif
    $display("frame mode=%0d bird_y=%0d col_x0=%0d busy_cycles=%0d collided=%0d", m_mode, bird_y, get_cx(0), cycles, coll);
  endtask

  task automatic restart_wait();
    for (int f = 0; f < 70 && m_mode == 2; f++) run_frame(0);
    chk("restart_state", int'(state), int'(ST_IDLE));
    chk("restart_bird_y", int'(bird_y), 240);
    chk("restart_col_x0", get_cx(0), 200);
    chk("restart_col_x5", get_cx(5), 1000);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; frame_tick = 1'b0; flap = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    model_init();

    // Reset values
    chk("reset_bird_y", int'(bird_y), 240);
    chk("reset_col_x0", get_cx(0), 200);
    chk("reset_col_x5", get_cx(5), 1000);
    chk("reset_state", int'(state), int'(ST_IDLE));
    chk("reset_collided", int'(collided), 0);
    chk("reset_busy", int'(busy), 0);

    // Tick without a flap keeps the game idle
    run_frame(0);

    // Start and flap physics
    press_flap();
    run_frame(0);
    chk("start_y", int'(bird_y), 234);
    run_frame(0);
    chk("fall1_y", int'(bird_y), 229);
    run_frame(0);
    chk("fall2_y", int'(bird_y), 225);

    // Column collision: hover near 240 until column 0 hits
    for (int f = 0; f < 200 && m_mode == 1; f++) begin
      maybe_flap(240);
      run_frame(1);
    end
    chk("col_death_state", int'(state), int'(ST_DEAD));
    chk("col_death_x", get_cx(0), 119);
    run_frame(0);
    chk("dead_frozen_x", get_cx(0), 119);
    restart_wait();

    // Ground collision: no flaps after start
    press_flap();
    run_frame(1);
    for (int f = 0; f < 200 && m_mode == 1; f++) run_frame(1);
    chk("ground_state", int'(state), int'(ST_DEAD));
    chk("ground_clamp_y", int'(bird_y), 450);
    restart_wait();

    // Wrap: fly through column 0's gap until it reaches x=0 and wraps
    press_flap();
    run_frame(1);
    for (int f = 0; f < 260 && m_mode == 1 && wraps_seen == 0; f++) begin
      maybe_flap(140);
      run_frame(1);
    end
    chk("wrap_seen", int'(wraps_seen > 0), 1);
    chk("wrap_col_x0", get_cx(0), 959);
    chk("wrap_state", int'(state), int'(ST_WAIT));
`ifdef FLAPPY_SCORE_EN
    chk("score_after_pass", int'(score), 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
